// File: rtl/btb_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch target buffer.
interface btb_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          fetch_pc;
  logic                 branch_prediction;
  logic [31:0]          pc_target_prediction;
  logic                 btb_hit;
  logic                 update_valid;
  logic [31:0]          update_pc;
  logic                 update_taken;
  logic [31:0]          update_target;
  logic                 update_prediction;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output fetch_pc, update_valid, update_pc, update_taken, update_target, update_prediction,
    input  branch_prediction, pc_target_prediction, btb_hit, mispredict_count
  );

  modport slave (
    input  fetch_pc, update_valid, update_pc, update_taken, update_target, update_prediction,
    output branch_prediction, pc_target_prediction, btb_hit, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a saturating
// mispredict counter. Lookup is combinational off registered state (no bypass).
module branch_predictor_btb #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic   clk,
  input logic   rst,
  btb_if.slave  bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [DEPTH-1:0][31:0]      target_q;
  logic [DEPTH-1:0][1:0]       ctr_q;
  logic [CNT_WIDTH-1:0]        miss_cnt_q;

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  wr_hit;
  logic                  unused_pc_lsbs;

  assign rd_idx = bus.fetch_pc[INDEX_BITS+1:2];
  assign rd_tag = bus.fetch_pc[31:INDEX_BITS+2];
  assign wr_idx = bus.update_pc[INDEX_BITS+1:2];
  assign wr_tag = bus.update_pc[31:INDEX_BITS+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  // Word-aligned PCs: byte offset carries no information for the table.
  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

  assign bus.btb_hit              = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign bus.branch_prediction    = bus.btb_hit && ctr_q[rd_idx][1];
  assign bus.pc_target_prediction = bus.branch_prediction ? target_q[rd_idx] : 32'd0;
  assign bus.mispredict_count     = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      tag_q      <= '0;
      target_q   <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (bus.update_valid) begin
      if (wr_hit) begin
        if (bus.update_taken) begin
          if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
          target_q[wr_idx] <= bus.update_target;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
        end
      end else if (bus.update_taken) begin
        // Allocate weak-taken, evicting whatever aliased here.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= bus.update_target;
        ctr_q[wr_idx]    <= 2'b10;
      end
      if ((bus.update_prediction != bus.update_taken) && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 4, number of index bits (table depth 2^INDEX_BITS = 16 entries).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, mispredict counter width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port fetch_pc  input  32  PC currently being fetched (lookup address).
REQ-006 The block SHALL have port branch_prediction  output  1  1 = predict taken for fetch_pc.
REQ-007 The block SHALL have port pc_target_prediction  output  32  predicted target for fetch_pc.
REQ-008 The block SHALL have port btb_hit  output  1  valid entry with matching tag exists for fetch_pc.
REQ-009 The block SHALL have port update_valid  input  1  a resolved branch is presented this cycle.
REQ-010 The block SHALL have port update_pc  input  32  PC of the resolved branch.
REQ-011 The block SHALL have port update_taken  input  1  actual branch outcome (1 = taken).
REQ-012 The block SHALL have port update_target  input  32  actual target from the address builder.
REQ-013 The block SHALL have port update_prediction  input  1  prediction flag propagated down the pipeline for this branch.
REQ-014 The block SHALL have port mispredict_count  output  CNT_WIDTH  number of mispredicted updates since reset.

Function
REQ-015 Each entry SHALL hold: valid (1), tag = pc[31:INDEX_BITS+2], target (32), 2-bit counter.
REQ-016 The index SHALL be pc[INDEX_BITS+1:2]; pc[1:0] SHALL be ignored.
REQ-017 Lookup SHALL be combinational from registered table state: btb_hit = valid && tag match at index(fetch_pc).
REQ-018 branch_prediction SHALL equal btb_hit && counter[1].
REQ-019 pc_target_prediction SHALL equal the entry target when branch_prediction = 1, else 32'd0.
REQ-020 Counter encoding SHALL be: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-021 On update_valid with tag hit: counter SHALL increment (saturate at 11) if update_taken = 1, else decrement (saturate at 00), taking effect next cycle.
REQ-022 On update_valid with tag hit and update_taken = 1, the target SHALL be overwritten with update_target.
REQ-023 On update_valid with miss (invalid or tag mismatch) and update_taken = 1, the entry SHALL be allocated: valid = 1, new tag, target = update_target, counter = 10; any previous occupant is evicted.
REQ-024 On update_valid with miss and update_taken = 0, the table SHALL NOT change.
REQ-025 With update_valid = 0, inputs update_* SHALL be ignored.
REQ-026 Same-cycle lookup and update to the same index SHALL return the pre-update contents (no bypass); the new value is visible from the next cycle.
REQ-027 mispredict_count SHALL increment by 1 on each cycle with update_valid = 1 and update_prediction != update_taken, saturating at all-ones (no wrap).
REQ-028 Update latency SHALL be exactly one clock; at most one update SHALL be accepted per cycle.

Reset
REQ-029 When rst = 1 at a rising edge, all valid bits SHALL clear, all counters SHALL become 01, all targets and tags SHALL become 0, and mispredict_count SHALL become 0.
REQ-030 An update coinciding with rst = 1 SHALL be discarded.
REQ-031 From the cycle after reset, branch_prediction = 0, btb_hit = 0, and pc_target_prediction = 32'd0 for every fetch_pc.

Verification
REQ-032 After reset, lookup of fetch_pc = 0x00000040 SHALL give btb_hit = 0, branch_prediction = 0, target 0x00000000, and mispredict_count = 0.
REQ-033 An update with pc 0x40, taken = 1, target 0x100, prediction = 0 SHALL give, next cycle, lookup 0x40 -> hit = 1, prediction = 1, target 0x100, and mispredict_count = 1.
REQ-034 Two not-taken updates to 0x40 starting from counter 10 SHALL give 01 then 00; lookup SHALL then give hit = 1, prediction = 0, target 0; a third not-taken update SHALL leave the counter at 00.
REQ-035 After 0x40 is allocated, a taken update to 0x440 (same index, different tag) with target 0x200 SHALL cause lookup 0x40 -> hit = 0 and lookup 0x440 -> prediction = 1, target 0x200.
REQ-036 A same-cycle lookup and allocating update of 0x80 SHALL give prediction = 0 in that cycle and prediction = 1 in the next cycle.
REQ-037 Forcing 2^CNT_WIDTH + 3 mispredicted updates SHALL hold mispredict_count at 0xFFFF, and asserting rst with update_valid = 1 SHALL give count 0 and an empty table.
